// File: rtl/router_pkt_fifo.sv
// Per-destination packet FIFO for the 1xN router: header-flagged entries, registered read
// data with a valid strobe, and read-side packet-length tracking with an end-of-packet pulse.
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] d_out,
  output logic              d_out_vld,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              pkt_active,
  output logic              pkt_end
);

  localparam int REM_W = DATA_W - 1;
  localparam int LEN_W = DATA_W - 2;

  // Each entry is {header_flag, data}.
  logic [DATA_W:0]   mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [REM_W-1:0]  rem_cnt_q, rem_cnt_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_out_vld_q, d_out_vld_d;
  logic              overflow_q, overflow_d;
  logic              pkt_end_q, pkt_end_d;

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W:0]   rd_word;
  logic [LEN_W-1:0]  rd_len;
  logic [ADDR_W:0]   count_w;

  // Extra pointer bit distinguishes full from empty; the difference is the exact occupancy.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
  assign rd_len  = rd_word[DATA_W-1:2];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rem_cnt_d   = rem_cnt_q;
    d_out_d     = d_out_q;
    d_out_vld_d = 1'b0;
    overflow_d  = 1'b0;
    pkt_end_d   = 1'b0;
    wr_ok       = 1'b0;
    rd_ok       = 1'b0;

    if (soft_rst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rem_cnt_d = '0;
      d_out_d   = '0;
    end else begin
      wr_ok      = wr_en && !full;
      rd_ok      = rd_en && !empty;
      overflow_d = wr_en && full;

      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
      end

      if (rd_ok) begin
        rd_ptr_d    = rd_ptr_q + (ADDR_W+1)'(1);
        d_out_d     = rd_word[DATA_W-1:0];
        d_out_vld_d = 1'b1;
        // A header always reloads, truncating any packet still in progress.
        if (rd_word[DATA_W]) begin
          rem_cnt_d = {1'b0, rd_len} + REM_W'(1);
        end else if (rem_cnt_q != '0) begin
          rem_cnt_d = rem_cnt_q - REM_W'(1);
          pkt_end_d = (rem_cnt_q == REM_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rem_cnt_q   <= '0;
      d_out_q     <= '0;
      d_out_vld_q <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_end_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_cnt_q   <= rem_cnt_d;
      d_out_q     <= d_out_d;
      d_out_vld_q <= d_out_vld_d;
      overflow_q  <= overflow_d;
      pkt_end_q   <= pkt_end_d;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, d_in};
    end
  end

  assign d_out       = d_out_q;
  assign d_out_vld   = d_out_vld_q;
  assign count       = count_w;
  assign empty       = (count_w == '0);
  assign full        = (count_w == (ADDR_W+1)'(DEPTH));
  assign almost_full = (count_w >= (ADDR_W+1)'(AF_LEVEL));
  assign overflow    = overflow_q;
  assign pkt_active  = (rem_cnt_q != '0);
  assign pkt_end     = pkt_end_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: reset, fill/overflow, packet tracking, wrap, simultaneous
// access and flush, all against hand-computed expectations.
module tb_router_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst, soft_rst, wr_en, lfd_state, rd_en;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_out_vld, empty, full, almost_full, overflow, pkt_active, pkt_end;
  logic [4:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(14)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .lfd_state(lfd_state),
    .d_in(d_in), .rd_en(rd_en), .d_out(d_out), .d_out_vld(d_out_vld), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .overflow(overflow),
    .pkt_active(pkt_active), .pkt_end(pkt_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic l, input logic [7:0] d, input logic r);
    wr_en = w; lfd_state = l; d_in = d; rd_en = r;
  endtask

  logic [7:0] hdr_pkt [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
  logic [7:0] sb [$];
  logic [7:0] exp_b;
  int wrote, got;
  bit do_wr, do_rd;

  initial begin
    rst = 1'b1; soft_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // T1 reset
    tick(); tick();
    check("t1_empty", empty, 1);
    check("t1_full", full, 0);
    check("t1_count", count, 0);
    check("t1_dout", d_out, 0);
    check("t1_vld", d_out_vld, 0);
    check("t1_active", pkt_active, 0);
    rst = 1'b0;

    // T2 fill 0x00..0x0F, almost_full from the 14th write
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0);
      tick();
      check($sformatf("t2_count%0d", i), count, i + 1);
      check($sformatf("t2_af%0d", i), almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    check("t2_full", full, 1);
    drive(1'b1, 1'b0, 8'hEE, 1'b0);
    tick();
    check("t2_ovf", overflow, 1);
    check("t2_ovf_count", count, 16);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("t2_ovf_pulse", overflow, 0);

    // T5a full + wr + rd: read accepted, write dropped
    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    tick();
    check("t5_full_count", count, 15);
    check("t5_full_ovf", overflow, 1);
    check("t5_full_vld", d_out_vld, 1);
    check("t5_full_dout", d_out, 8'h00);

    // Drain the rest; data is stray (no header) so no packet tracking
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("t2_drain%0d", i), d_out, i);
      check($sformatf("t2_pend%0d", i), pkt_end, 0);
    end
    check("t2_drained", empty, 1);
    check("t2_stray_active", pkt_active, 0);

    // T5b empty + wr + rd: write only, no bypass
    drive(1'b1, 1'b0, 8'h99, 1'b1);
    tick();
    check("t5_empty_count", count, 1);
    check("t5_empty_vld", d_out_vld, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("t5_empty_dout", d_out, 8'h99);
    check("t5_empty_vld2", d_out_vld, 1);

    // T3 packet: header LEN=3, three payload words, parity
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0) ? 1'b1 : 1'b0, hdr_pkt[i], 1'b0);
      tick();
    end
    check("t3_count", count, 5);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("t3_dout%0d", i), d_out, hdr_pkt[i]);
      check($sformatf("t3_vld%0d", i), d_out_vld, 1);
      check($sformatf("t3_active%0d", i), pkt_active, (i < 4) ? 1 : 0);
      check($sformatf("t3_pend%0d", i), pkt_end, (i == 4) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("t3_pend_pulse", pkt_end, 0);
    check("t3_vld_idle", d_out_vld, 0);
    check("t3_dout_hold", d_out, 8'h5C);

    // T4 wrap: 40 writes with interleaved reads, at most 10 in flight
    wrote = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      do_wr = (wrote < 40) && (sb.size() < 10) && (cyc % 4 != 3);
      do_rd = (sb.size() > 0) && ((cyc % 3 == 0) || (wrote == 40));
      drive(do_wr, 1'b0, 8'(8'h40 + wrote), do_rd);
      tick();
      if (do_rd) begin
        exp_b = sb.pop_front();
        check($sformatf("t4_data%0d", got), d_out, exp_b);
        got++;
      end
      if (do_wr) begin
        sb.push_back(8'(8'h40 + wrote));
        wrote++;
      end
      check("t4_count", count, sb.size());
    end
    check("t4_all_read", got, 40);

    // T6 flush mid-packet: 8 written, header + one payload read -> count 6, rem 3
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 1'b1 : 1'b0, (i < 5) ? hdr_pkt[i] : 8'(8'h11 * (i - 4)), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick(); tick();
    check("t6_pre_count", count, 6);
    check("t6_pre_active", pkt_active, 1);
    check("t6_pre_dout", d_out, 8'hA1);
    soft_rst = 1'b1;
    drive(1'b1, 1'b0, 8'hBB, 1'b1);
    tick();
    soft_rst = 1'b0;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_active", pkt_active, 0);
    check("t6_dout", d_out, 0);
    check("t6_vld", d_out_vld, 0);
    drive(1'b1, 1'b0, 8'h77, 1'b0);
    tick();
    check("t6_wr_count", count, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("t6_rd_dout", d_out, 8'h77);
    check("t6_rd_vld", d_out_vld, 1);
    check("t6_rd_empty", empty, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
